// File: rtl/aes_pkg.sv
// Shared types and constants for the AES round-constant sequencer.
package aes_pkg;

    typedef enum logic [1:0] {
        AES128      = 2'd0,
        AES192      = 2'd1,
        AES256      = 2'd2,
        AES_ILLEGAL = 2'd3
    } aes_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_EMIT  = 2'd2
    } rcon_state_t;

    localparam logic [7:0] AES_POLY = 8'h1B;

    // Number of round constants consumed by each key schedule; 0 flags an illegal mode.
    function automatic logic [3:0] RCON_COUNT(input aes_mode_t m);
        case (m)
            AES128:  return 4'd10;
            AES192:  return 4'd8;
            AES256:  return 4'd7;
            default: return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/gf_xtime_step.sv
// One GF(2^8) doubling step, or its inverse, selected by inv.
// The inverse relies on POLY[0] being 1: a set LSB in the result can only come from the reduction.
module gf_xtime_step #(
    parameter int             W    = 8,
    parameter logic [W-1:0]   POLY = 8'h1B
) (
    input  logic [W-1:0] a,
    input  logic         inv,
    output logic [W-1:0] y
);

    logic [W-1:0] fwd_val;
    logic [W-1:0] bwd_val;

    assign fwd_val = {a[W-2:0], 1'b0} ^ (a[W-1] ? POLY : '0);
    assign bwd_val = a[0] ? ({1'b1, a[W-1:1]} ^ (POLY >> 1)) : {1'b0, a[W-1:1]};
    assign y       = inv ? bwd_val : fwd_val;

endmodule

// File: rtl/aes_rcon_seq.sv
// Streams the AES key-schedule round constants, forward or reverse, without a lookup table.
//
//   state    | meaning
//   ---------+----------------------------------------------------------------
//   ST_IDLE  | waiting for start; rcon outputs forced to zero
//   ST_PRIME | reverse only: doubling 01 up to Rcon[N], valid held low
//   ST_EMIT  | presenting rcon/idx with valid; stepping on each accept
module aes_rcon_seq
    import aes_pkg::*;
#(
    parameter int           W          = 8,
    parameter logic [W-1:0] POLY       = AES_POLY,
    parameter bit           REVERSE_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic [1:0]   mode,
    input  logic         dir,
    output logic         rcon_valid,
    input  logic         rcon_ready,
    output logic [W-1:0] rcon,
    output logic [3:0]   rcon_idx,
    output logic         rcon_last,
    output logic         busy,
    output logic         done,
    output logic         err
);

    rcon_state_t  state_q, state_d;
    logic [W-1:0] rcon_q, rcon_d;
    logic [3:0]   idx_q, idx_d;
    logic [3:0]   n_q, n_d;
    logic         dir_q, dir_d;
    logic         done_q, done_d;
    logic         err_q, err_d;

    logic [W-1:0] step_val;
    logic         step_inv;
    logic         in_emit;
    logic         is_last;
    logic [3:0]   mode_n;

    // PRIME always doubles; EMIT walks back down only in reverse.
    assign step_inv = (state_q == ST_EMIT) && dir_q;

    gf_xtime_step #(
        .W    (W),
        .POLY (POLY)
    ) u_step (
        .a   (rcon_q),
        .inv (step_inv),
        .y   (step_val)
    );

    assign in_emit = (state_q == ST_EMIT);
    assign is_last = in_emit && (dir_q ? (idx_q == 4'd1) : (idx_q == n_q));
    assign mode_n  = RCON_COUNT(aes_mode_t'(mode));

    // Next-state, datapath update and pulse generation.
    always_comb begin
        state_d = state_q;
        rcon_d  = rcon_q;
        idx_d   = idx_q;
        n_d     = n_q;
        dir_d   = dir_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (aes_mode_t'(mode) == AES_ILLEGAL) begin
                            err_d = 1'b1;
                        end else begin
                            n_d     = mode_n;
                            dir_d   = dir & REVERSE_EN;
                            rcon_d  = W'(1);
                            idx_d   = 4'd1;
                            state_d = (dir & REVERSE_EN) ? ST_PRIME : ST_EMIT;
                        end
                    end
                end
                ST_PRIME: begin
                    rcon_d = step_val;
                    idx_d  = idx_q + 4'd1;
                    if (idx_q + 4'd1 == n_q) begin
                        state_d = ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (rcon_ready) begin
                        if (is_last) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            rcon_d = step_val;
                            idx_d  = dir_q ? (idx_q - 4'd1) : (idx_q + 4'd1);
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rcon_q  <= W'(1);
            idx_q   <= 4'd0;
            n_q     <= 4'd0;
            dir_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rcon_q  <= rcon_d;
            idx_q   <= idx_d;
            n_q     <= n_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Stream outputs read zero outside EMIT so reset drops them immediately.
    assign rcon_valid = in_emit;
    assign rcon       = in_emit ? rcon_q : '0;
    assign rcon_idx   = in_emit ? idx_q : 4'd0;
    assign rcon_last  = is_last;
    assign busy       = (state_q == ST_PRIME) || in_emit;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_aes_rcon_seq.sv
// Bench for aes_rcon_seq: scenario tasks against a GF(2^8) power-of-two reference model.
module tb_aes_rcon_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [1:0] mode;
    logic       dir;
    logic       rcon_valid;
    logic       rcon_ready;
    logic [7:0] rcon;
    logic [3:0] rcon_idx;
    logic       rcon_last;
    logic       busy;
    logic       done;
    logic       err;

    int total = 0;
    int bad   = 0;

    int obs_rcon[$];
    int obs_idx[$];
    int obs_last[$];
    int exp_rcon[$];
    int exp_idx[$];
    int lat;
    int hold_viol;
    int stall_cnt;
    int timed_out;
    logic done_v1, valid_v1, done_v2;

    aes_rcon_seq u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .mode       (mode),
        .dir        (dir),
        .rcon_valid (rcon_valid),
        .rcon_ready (rcon_ready),
        .rcon       (rcon),
        .rcon_idx   (rcon_idx),
        .rcon_last  (rcon_last),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Rcon[i] = x^(i-1) in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic int gf_pow2(input int i);
        int v = 1;
        for (int k = 1; k < i; k++) begin
            v = v * 2;
            if (v > 255) v = v ^ 'h11B;
        end
        return v;
    endfunction

    function automatic int n_of(input int m);
        case (m)
            0: return 10;
            1: return 8;
            2: return 7;
            default: return 0;
        endcase
    endfunction

    task automatic build_exp(input int m, input int d);
        int n = n_of(m);
        exp_rcon.delete();
        exp_idx.delete();
        for (int k = 0; k < n; k++) begin
            int i = (d != 0) ? (n - k) : (k + 1);
            exp_rcon.push_back(gf_pow2(i));
            exp_idx.push_back(i);
        end
    endtask

    // Drives one sequence and records what came out; judging is left to the callers.
    // rdy_mode: 0 = ready high, 1 = repeating 1,0,0,1 per valid cycle, 2 = random.
    task automatic collect(input int m, input int d, input int rdy_mode);
        int   cyc = 0;
        int   pat = 0;
        int   phase = 0;
        bit   prev_stall = 0;
        bit   rdy;
        logic [7:0] p_rcon = 8'h00;
        logic [3:0] p_idx = 4'h0;
        logic       p_last = 1'b0;
        obs_rcon.delete();
        obs_idx.delete();
        obs_last.delete();
        lat = -1; hold_viol = 0; stall_cnt = 0; timed_out = 0;
        done_v1 = 1'b0; valid_v1 = 1'b1; done_v2 = 1'b1;
        @(negedge clk);
        start = 1'b1; abort = 1'b0; mode = m[1:0]; dir = d[0]; rcon_ready = 1'b0;
        while (phase < 3) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            mode = 2'($urandom_range(0, 3));
            dir  = 1'($urandom_range(0, 1));
            if (cyc > 300) begin
                timed_out = 1;
                break;
            end
            if (phase == 2) begin
                done_v2 = done;
                phase = 3;
            end else if (phase == 1) begin
                done_v1 = done;
                valid_v1 = rcon_valid;
                phase = 2;
            end else begin
                if (rcon_valid && lat < 0) lat = cyc;
                if (prev_stall && (!rcon_valid || rcon !== p_rcon || rcon_idx !== p_idx || rcon_last !== p_last))
                    hold_viol++;
                case (rdy_mode)
                    0: rdy = 1'b1;
                    1: begin
                        rdy = (pat % 4 == 0) || (pat % 4 == 3);
                        if (rcon_valid) pat++;
                    end
                    default: rdy = 1'($urandom_range(0, 1));
                endcase
                rcon_ready = rdy;
                prev_stall = rcon_valid && !rdy;
                if (prev_stall) stall_cnt++;
                p_rcon = rcon; p_idx = rcon_idx; p_last = rcon_last;
                if (rcon_valid && rdy) begin
                    obs_rcon.push_back(int'(rcon));
                    obs_idx.push_back(int'(rcon_idx));
                    obs_last.push_back(int'(rcon_last));
                    if (rcon_last) phase = 1;
                end
                if (busy) start = 1'($urandom_range(0, 1));
            end
        end
        start = 1'b0;
        rcon_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 2'd0; dir = 1'b0; rcon_ready = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({rcon_valid, rcon, rcon_idx, rcon_last, busy, done, err} !== 17'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %05h, want 00000", {rcon_valid, rcon, rcon_idx, rcon_last, busy, done, err});
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({rcon_valid, busy, done, err} !== 4'd0) begin
            bad++;
            $display("FAIL idle_after_reset: got %04b, want 0000", {rcon_valid, busy, done, err});
        end
    endtask

    task automatic test_fwd128;
        int n = 10;
        build_exp(0, 0);
        collect(0, 0, 0);
        total++;
        if (timed_out != 0 || obs_rcon.size() != n) begin
            bad++;
            $display("FAIL fwd128_count: got %0d beats timeout=%0d, want %0d", obs_rcon.size(), timed_out, n);
        end
        for (int i = 0; i < obs_rcon.size() && i < n; i++) begin
            total++;
            if (obs_rcon[i] != exp_rcon[i] || obs_idx[i] != exp_idx[i] || obs_last[i] != ((i == n - 1) ? 1 : 0)) begin
                bad++;
                $display("FAIL fwd128_beat%0d: got rcon=%02h idx=%0d last=%0d, want rcon=%02h idx=%0d last=%0d",
                         i, obs_rcon[i], obs_idx[i], obs_last[i], exp_rcon[i], exp_idx[i], (i == n - 1) ? 1 : 0);
            end
        end
        total++;
        if (lat != 1) begin
            bad++;
            $display("FAIL fwd128_latency: got %0d, want 1", lat);
        end
        total++;
        if (done_v1 !== 1'b1 || valid_v1 !== 1'b0 || done_v2 !== 1'b0) begin
            bad++;
            $display("FAIL fwd128_done: got done=%b valid=%b next_done=%b, want 1 0 0", done_v1, valid_v1, done_v2);
        end
    endtask

    task automatic test_reverse(input int m);
        int n = n_of(m);
        build_exp(m, 1);
        collect(m, 1, 0);
        total++;
        if (timed_out != 0 || obs_rcon.size() != n) begin
            bad++;
            $display("FAIL rev_m%0d_count: got %0d beats timeout=%0d, want %0d", m, obs_rcon.size(), timed_out, n);
        end
        for (int i = 0; i < obs_rcon.size() && i < n; i++) begin
            total++;
            if (obs_rcon[i] != exp_rcon[i] || obs_idx[i] != exp_idx[i] || obs_last[i] != ((i == n - 1) ? 1 : 0)) begin
                bad++;
                $display("FAIL rev_m%0d_beat%0d: got rcon=%02h idx=%0d last=%0d, want rcon=%02h idx=%0d last=%0d",
                         m, i, obs_rcon[i], obs_idx[i], obs_last[i], exp_rcon[i], exp_idx[i], (i == n - 1) ? 1 : 0);
            end
        end
        total++;
        if (lat != n) begin
            bad++;
            $display("FAIL rev_m%0d_latency: got %0d, want %0d", m, lat, n);
        end
        total++;
        if (done_v1 !== 1'b1 || done_v2 !== 1'b0) begin
            bad++;
            $display("FAIL rev_m%0d_done: got done=%b next_done=%b, want 1 0", m, done_v1, done_v2);
        end
    endtask

    task automatic test_backpressure;
        int n = 8;
        build_exp(1, 0);
        collect(1, 0, 1);
        total++;
        if (timed_out != 0 || obs_rcon.size() != n) begin
            bad++;
            $display("FAIL bp_count: got %0d beats timeout=%0d, want %0d", obs_rcon.size(), timed_out, n);
        end
        for (int i = 0; i < obs_rcon.size() && i < n; i++) begin
            total++;
            if (obs_rcon[i] != exp_rcon[i] || obs_idx[i] != exp_idx[i]) begin
                bad++;
                $display("FAIL bp_beat%0d: got rcon=%02h idx=%0d, want rcon=%02h idx=%0d",
                         i, obs_rcon[i], obs_idx[i], exp_rcon[i], exp_idx[i]);
            end
        end
        total++;
        if (stall_cnt == 0 || hold_viol != 0) begin
            bad++;
            $display("FAIL bp_hold: got stalls=%0d hold_violations=%0d, want stalls>0 violations=0", stall_cnt, hold_viol);
        end
    endtask

    task automatic test_err;
        @(negedge clk);
        start = 1'b1; mode = 2'd3; dir = 1'b0;
        @(negedge clk);
        start = 1'b0;
        total++;
        if ({err, busy, rcon_valid} !== 3'b100) begin
            bad++;
            $display("FAIL err_pulse: got err/busy/valid=%03b, want 100", {err, busy, rcon_valid});
        end
        @(negedge clk);
        total++;
        if ({err, busy, rcon_valid} !== 3'b000) begin
            bad++;
            $display("FAIL err_clear: got err/busy/valid=%03b, want 000", {err, busy, rcon_valid});
        end
    endtask

    task automatic test_abort;
        int guard = 0;
        int done_seen = 0;
        @(negedge clk);
        start = 1'b1; mode = 2'd0; dir = 1'b0; rcon_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!(rcon_valid && rcon_idx == 4'd3) && guard < 30) begin
            @(negedge clk);
            guard++;
        end
        total++;
        if (guard >= 30) begin
            bad++;
            $display("FAIL abort_reach_beat3: got no beat 3 in %0d cycles, want beat 3", guard);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0; rcon_ready = 1'b0;
        total++;
        if ({rcon_valid, busy} !== 2'b00) begin
            bad++;
            $display("FAIL abort_idle: got valid/busy=%02b, want 00", {rcon_valid, busy});
        end
        for (int i = 0; i < 3; i++) begin
            if (done) done_seen++;
            @(negedge clk);
        end
        total++;
        if (done_seen != 0) begin
            bad++;
            $display("FAIL abort_no_done: got %0d done cycles, want 0", done_seen);
        end
        start = 1'b1; abort = 1'b1; mode = 2'd0;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        total++;
        if ({rcon_valid, busy} !== 2'b00) begin
            bad++;
            $display("FAIL abort_beats_start: got valid/busy=%02b, want 00", {rcon_valid, busy});
        end
        collect(0, 0, 0);
        total++;
        if (obs_rcon.size() != 10 || obs_rcon[0] != 'h01 || obs_idx[0] != 1) begin
            bad++;
            $display("FAIL abort_restart: got %0d beats first=%02h, want 10 beats first=01",
                     obs_rcon.size(), (obs_rcon.size() > 0) ? obs_rcon[0] : -1);
        end
    endtask

    task automatic test_reset_mid;
        int guard = 0;
        @(negedge clk);
        start = 1'b1; mode = 2'd0; dir = 1'b1; rcon_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        while (!rcon_valid && guard < 30) begin
            @(negedge clk);
            guard++;
        end
        total++;
        if (guard >= 30) begin
            bad++;
            $display("FAIL rstmid_reach_emit: got no valid in %0d cycles, want valid", guard);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({rcon_valid, rcon, rcon_idx, rcon_last, busy, done, err} !== 17'd0) begin
            bad++;
            $display("FAIL rstmid_async: got %05h, want 00000", {rcon_valid, rcon, rcon_idx, rcon_last, busy, done, err});
        end
        @(negedge clk);
        rst_n = 1'b1;
        collect(0, 0, 0);
        total++;
        if (obs_rcon.size() != 10 || obs_rcon[0] != 'h01 || obs_idx[0] != 1) begin
            bad++;
            $display("FAIL rstmid_restart: got %0d beats first=%02h, want 10 beats first=01",
                     obs_rcon.size(), (obs_rcon.size() > 0) ? obs_rcon[0] : -1);
        end
    endtask

    task automatic test_random;
        for (int t = 0; t < 8; t++) begin
            int m = int'($urandom_range(0, 2));
            int d = int'($urandom_range(0, 1));
            int n = n_of(m);
            build_exp(m, d);
            collect(m, d, 2);
            total++;
            if (timed_out != 0 || obs_rcon.size() != n || hold_viol != 0) begin
                bad++;
                $display("FAIL rand%0d_stream: got %0d beats timeout=%0d holdviol=%0d, want %0d beats 0 0",
                         t, obs_rcon.size(), timed_out, hold_viol, n);
            end
            for (int i = 0; i < obs_rcon.size() && i < n; i++) begin
                total++;
                if (obs_rcon[i] != exp_rcon[i] || obs_idx[i] != exp_idx[i] || obs_last[i] != ((i == n - 1) ? 1 : 0)) begin
                    bad++;
                    $display("FAIL rand%0d_beat%0d (m=%0d d=%0d): got rcon=%02h idx=%0d last=%0d, want rcon=%02h idx=%0d last=%0d",
                             t, i, m, d, obs_rcon[i], obs_idx[i], obs_last[i], exp_rcon[i], exp_idx[i], (i == n - 1) ? 1 : 0);
                end
            end
            total++;
            if (done_v1 !== 1'b1 || done_v2 !== 1'b0) begin
                bad++;
                $display("FAIL rand%0d_done: got done=%b next_done=%b, want 1 0", t, done_v1, done_v2);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fwd128();
        test_reverse(2);
        test_reverse(1);
        test_reverse(0);
        test_backpressure();
        test_err();
        test_abort();
        test_reset_mid();
        test_random();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
